// File: rtl/c1541_gcr_decoder.sv
// c1541_gcr_decoder: 1541 GCR track-stream decoder. Hunts sync marks, turns
// each 10-bit GCR group back into a byte, parses header and data blocks and
// writes data-block payload into the track buffer RAM.
// Ports:
//   clk32, reset_n        clock and synchronous active-low reset
//   mtr                   spindle motor on; low forces HUNT and blocks writes
//   bit_en, bit_in        serial GCR bit and its one-cycle valid strobe
//   track                 current head track
//   sync_n                low while inside a sync mark
//   sector                sector number from the last valid header
//   byte_addr, ram_di     RAM write address and data
//   ram_we                one-cycle RAM write strobe
//   sector_done, data_ok  end-of-data-block pulse and its verdict
//   hdr_err, gcr_err      header failure and invalid-code pulses
module c1541_gcr_decoder #(
    parameter int unsigned SYNC_BITS   = 10,
    parameter logic [7:0]  HDR_ID      = 8'h08,
    parameter logic [7:0]  DATA_ID     = 8'h07,
    parameter bit          CHECK_TRACK = 1'b1
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       mtr,
    input  logic       bit_en,
    input  logic       bit_in,
    input  logic [5:0] track,
    output logic       sync_n,
    output logic [4:0] sector,
    output logic [7:0] byte_addr,
    output logic [7:0] ram_di,
    output logic       ram_we,
    output logic       sector_done,
    output logic       data_ok,
    output logic       hdr_err,
    output logic       gcr_err
);

    localparam int OW = $clog2(SYNC_BITS + 1);

    typedef enum logic [1:0] {HUNT, ID, HEADER, DATA} state_t;

    state_t        state, state_nx;
    logic [OW-1:0] ones_cnt, ones_nx;
    logic [8:0]    shift;
    logic [3:0]    bit_cnt;
    logic [8:0]    byte_cnt;
    logic [7:0]    cks, xsum, sec_tmp, trk_tmp, hdr_trk;
    logic          bad, armed;

    logic       sync_start, sync_end, grp_done, code_bad, wr_ok, hdr_ok;
    logic [4:0] hi_dec, lo_dec;
    logic [9:0] group;
    logic [7:0] grp_byte;

    // Returns {valid, nibble}; invalid codes decode to nibble 0.
    function automatic logic [4:0] gcr_dec(input logic [4:0] c);
        case (c)
            5'b01010: gcr_dec = 5'h10;
            5'b01011: gcr_dec = 5'h11;
            5'b10010: gcr_dec = 5'h12;
            5'b10011: gcr_dec = 5'h13;
            5'b01110: gcr_dec = 5'h14;
            5'b01111: gcr_dec = 5'h15;
            5'b10110: gcr_dec = 5'h16;
            5'b10111: gcr_dec = 5'h17;
            5'b01001: gcr_dec = 5'h18;
            5'b11001: gcr_dec = 5'h19;
            5'b11010: gcr_dec = 5'h1A;
            5'b11011: gcr_dec = 5'h1B;
            5'b01101: gcr_dec = 5'h1C;
            5'b11101: gcr_dec = 5'h1D;
            5'b11110: gcr_dec = 5'h1E;
            5'b10101: gcr_dec = 5'h1F;
            default:  gcr_dec = 5'h00;
        endcase
    endfunction

    always_comb begin
        ones_nx = '0;
        if (bit_in)
            ones_nx = (ones_cnt == OW'(SYNC_BITS)) ? ones_cnt : ones_cnt + 1'b1;
        sync_start = bit_en && bit_in && (ones_cnt == OW'(SYNC_BITS - 1));
        // The 0 that ends a sync mark is already the MSB of the first group.
        sync_end   = bit_en && !bit_in && !sync_n;
        grp_done   = bit_en && mtr && sync_n && !sync_start &&
                     (state != HUNT) && (bit_cnt == 4'd9);
        group      = {shift, bit_in};
        hi_dec     = gcr_dec(group[9:5]);
        lo_dec     = gcr_dec(group[4:0]);
        grp_byte   = {hi_dec[3:0], lo_dec[3:0]};
        code_bad   = !hi_dec[4] || !lo_dec[4];
        wr_ok      = mtr && (!CHECK_TRACK || (hdr_trk == {2'b00, track}));
        hdr_ok     = ((xsum ^ grp_byte) == cks) && !bad && !code_bad;
    end

    always_comb begin
        state_nx = state;
        if (!mtr || sync_start) begin
            state_nx = HUNT;
        end else if (sync_end) begin
            state_nx = ID;
        end else if (grp_done) begin
            case (state)
                ID: begin
                    if (grp_byte == HDR_ID)
                        state_nx = HEADER;
                    else if (grp_byte == DATA_ID && armed)
                        state_nx = DATA;
                    else
                        state_nx = HUNT;
                end
                HEADER: if (byte_cnt == 9'd4) state_nx = HUNT;
                DATA:   if (byte_cnt == 9'd256) state_nx = HUNT;
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk32) begin
        if (!reset_n)
            state <= HUNT;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            ones_cnt    <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            cks         <= '0;
            xsum        <= '0;
            sec_tmp     <= '0;
            trk_tmp     <= '0;
            hdr_trk     <= '0;
            bad         <= 1'b0;
            armed       <= 1'b0;
            sync_n      <= 1'b1;
            sector      <= '0;
            byte_addr   <= '0;
            ram_di      <= '0;
            ram_we      <= 1'b0;
            sector_done <= 1'b0;
            data_ok     <= 1'b0;
            hdr_err     <= 1'b0;
            gcr_err     <= 1'b0;
        end else begin
            ram_we      <= 1'b0;
            sector_done <= 1'b0;
            data_ok     <= 1'b0;
            hdr_err     <= 1'b0;
            gcr_err     <= 1'b0;
            if (bit_en) begin
                ones_cnt <= ones_nx;
                shift    <= {shift[7:0], bit_in};
                if (sync_end)
                    bit_cnt <= 4'd1;
                else
                    bit_cnt <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                if (sync_start) begin
                    sync_n <= 1'b0;
                end else if (sync_end) begin
                    sync_n <= 1'b1;
                    bad    <= 1'b0;
                end
            end
            // An aborted data block must not be followed by a second one.
            if ((!mtr || sync_start) && state == DATA)
                armed <= 1'b0;
            if (grp_done) begin
                if (code_bad) begin
                    gcr_err <= 1'b1;
                    bad     <= 1'b1;
                end
                case (state)
                    ID: begin
                        byte_cnt <= '0;
                        xsum     <= '0;
                    end
                    HEADER: begin
                        byte_cnt <= byte_cnt + 9'd1;
                        case (byte_cnt[2:0])
                            3'd0: cks <= grp_byte;
                            3'd1: begin
                                sec_tmp <= grp_byte;
                                xsum    <= xsum ^ grp_byte;
                            end
                            3'd2: begin
                                trk_tmp <= grp_byte;
                                xsum    <= xsum ^ grp_byte;
                            end
                            3'd3: xsum <= xsum ^ grp_byte;
                            default: begin
                                if (hdr_ok) begin
                                    sector  <= sec_tmp[4:0];
                                    hdr_trk <= trk_tmp;
                                    armed   <= 1'b1;
                                end else begin
                                    hdr_err <= 1'b1;
                                    armed   <= 1'b0;
                                end
                            end
                        endcase
                    end
                    DATA: begin
                        byte_cnt <= byte_cnt + 9'd1;
                        if (byte_cnt != 9'd256) begin
                            xsum      <= xsum ^ grp_byte;
                            ram_di    <= grp_byte;
                            byte_addr <= byte_cnt[7:0];
                            ram_we    <= wr_ok;
                        end else begin
                            sector_done <= 1'b1;
                            data_ok     <= (xsum == grp_byte) && !bad &&
                                           !code_bad && wr_ok;
                            armed       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_c1541_gcr_decoder.sv
// tb_c1541_gcr_decoder: directed bench for c1541_gcr_decoder. Streams GCR
// encoded header/data blocks bit by bit and checks writes and status pulses.
module tb_c1541_gcr_decoder;

    logic       clk32   = 1'b0;
    logic       reset_n = 1'b0;
    logic       mtr     = 1'b0;
    logic       bit_en  = 1'b0;
    logic       bit_in  = 1'b0;
    logic [5:0] track   = 6'd18;
    logic       sync_n, ram_we, sector_done, data_ok, hdr_err, gcr_err;
    logic [4:0] sector;
    logic [7:0] byte_addr, ram_di;

    c1541_gcr_decoder dut (
        .clk32       (clk32),
        .reset_n     (reset_n),
        .mtr         (mtr),
        .bit_en      (bit_en),
        .bit_in      (bit_in),
        .track       (track),
        .sync_n      (sync_n),
        .sector      (sector),
        .byte_addr   (byte_addr),
        .ram_di      (ram_di),
        .ram_we      (ram_we),
        .sector_done (sector_done),
        .data_ok     (data_ok),
        .hdr_err     (hdr_err),
        .gcr_err     (gcr_err)
    );

    always #15 clk32 = ~clk32;

    logic [4:0] enc [16] = '{
        5'b01010, 5'b01011, 5'b10010, 5'b10011,
        5'b01110, 5'b01111, 5'b10110, 5'b10111,
        5'b01001, 5'b11001, 5'b11010, 5'b11011,
        5'b01101, 5'b11101, 5'b11110, 5'b10101
    };

    int errs   = 0;
    int checks = 0;

    int we_cnt = 0, match_cnt = 0, done_cnt = 0, ok_cnt = 0;
    int herr_cnt = 0, gerr_cnt = 0, long_cnt = 0, last_addr = -1;
    int b_we, b_match, b_done, b_ok, b_herr, b_gerr;
    logic p_we = 0, p_sd = 0, p_he = 0, p_ge = 0;

    always @(negedge clk32) begin
        if (ram_we) begin
            we_cnt++;
            if (byte_addr == ram_di) match_cnt++;
            last_addr = int'(byte_addr);
        end
        if (sector_done) begin
            done_cnt++;
            if (data_ok) ok_cnt++;
        end
        if (hdr_err) herr_cnt++;
        if (gcr_err) gerr_cnt++;
        if ((ram_we && p_we) || (sector_done && p_sd) ||
            (hdr_err && p_he) || (gcr_err && p_ge))
            long_cnt++;
        p_we = ram_we;
        p_sd = sector_done;
        p_he = hdr_err;
        p_ge = gcr_err;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_we    = we_cnt;
        b_match = match_cnt;
        b_done  = done_cnt;
        b_ok    = ok_cnt;
        b_herr  = herr_cnt;
        b_gerr  = gerr_cnt;
    endtask

    task automatic idle(input int n);
        bit_en = 1'b0;
        repeat (n) @(negedge clk32);
    endtask

    // Back-to-back calls keep bit_en high on consecutive cycles.
    task automatic send_bit(input logic b);
        bit_en = 1'b1;
        bit_in = b;
        @(negedge clk32);
        bit_en = 1'b0;
    endtask

    task automatic send_sync(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    task automatic send_code(input logic [9:0] c);
        for (int i = 9; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_code({enc[b[7:4]], enc[b[3:0]]});
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(8'(i));
    endtask

    task automatic send_header(input logic [7:0] c, input logic [7:0] s);
        send_sync(40);
        send_byte(8'h08);
        send_byte(c);
        send_byte(s);
        send_byte(8'h12);
        send_byte(8'h42);
        send_byte(8'h41);
        send_byte(8'h0F);
        send_byte(8'h0F);
        idle(3);
    endtask

    task automatic send_data(input logic [7:0] c);
        send_sync(40);
        send_byte(8'h07);
        send_range(0, 255);
        send_byte(c);
        idle(4);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sync_n"}, int'(sync_n), 1);
        chk({tag, "_sector"}, int'(sector), 0);
        chk({tag, "_addr"}, int'(byte_addr), 0);
        chk({tag, "_di"}, int'(ram_di), 0);
        chk({tag, "_pulses"},
            int'({ram_we, sector_done, data_ok, hdr_err, gcr_err}), 0);
    endtask

    initial begin
        idle(3);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        mtr     = 1'b1;
        idle(2);

        mark();
        send_sync(40);
        chk("sync_low", int'(sync_n), 0);
        send_byte(8'h08);
        chk("sync_end", int'(sync_n), 1);
        send_range(0, -1);
        send_byte(8'h12);
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h42);
        send_byte(8'h41);
        idle(3);
        chk("hdr_sector", int'(sector), 3);
        chk("hdr_noerr", herr_cnt - b_herr, 0);

        mark();
        send_data(8'h00);
        chk("d1_we", we_cnt - b_we, 256);
        chk("d1_addr", match_cnt - b_match, 256);
        chk("d1_last", last_addr, 255);
        chk("d1_done", done_cnt - b_done, 1);
        chk("d1_ok", ok_cnt - b_ok, 1);

        send_header(8'h12, 8'h03);
        mark();
        send_data(8'h01);
        chk("d2_we", we_cnt - b_we, 256);
        chk("d2_done", done_cnt - b_done, 1);
        chk("d2_ok", ok_cnt - b_ok, 0);

        mark();
        send_header(8'h13, 8'h05);
        chk("bh_err", herr_cnt - b_herr, 1);
        chk("bh_sector", int'(sector), 3);
        send_data(8'h00);
        chk("bh_we", we_cnt - b_we, 0);
        chk("bh_done", done_cnt - b_done, 0);

        send_header(8'h1E, 8'h0F);
        chk("h2_sector", int'(sector), 15);
        mark();
        send_sync(40);
        send_byte(8'h07);
        send_range(0, 9);
        send_code({5'b00000, enc[4'hA]});
        send_range(11, 255);
        send_byte(8'h00);
        idle(4);
        chk("gcr_err", gerr_cnt - b_gerr, 1);
        chk("gcr_done", done_cnt - b_done, 1);
        chk("gcr_ok", ok_cnt - b_ok, 0);

        send_header(8'h12, 8'h03);
        track = 6'd19;
        mark();
        send_data(8'h00);
        chk("trk_we", we_cnt - b_we, 0);
        chk("trk_done", done_cnt - b_done, 1);
        chk("trk_ok", ok_cnt - b_ok, 0);
        track = 6'd18;

        send_header(8'h12, 8'h03);
        mark();
        send_sync(40);
        send_byte(8'h07);
        send_range(0, 100);
        send_sync(12);
        idle(3);
        chk("ab_sync", int'(sync_n), 0);
        chk("ab_we", we_cnt - b_we, 101);
        chk("ab_last", last_addr, 100);
        chk("ab_done", done_cnt - b_done, 0);
        mark();
        send_byte(8'h07);
        send_range(0, 255);
        send_byte(8'h00);
        idle(4);
        chk("ab_disarm", we_cnt - b_we + done_cnt - b_done, 0);

        send_header(8'h12, 8'h03);
        mark();
        send_sync(40);
        send_byte(8'h07);
        send_range(0, 49);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset_n = 1'b0;
        idle(2);
        chk_reset_outputs("mid_rst");
        reset_n = 1'b1;
        send_code({5'b00000, enc[4'h2]});
        send_range(51, 255);
        send_byte(8'h00);
        idle(4);
        chk("rst_we", we_cnt - b_we, 50);
        chk("rst_done", done_cnt - b_done, 0);
        chk("pulse_width", long_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
